// File: rtl/icarus_pkg.sv
// Shared definitions for the Icarus work controller.
//   state_t      : controller FSM states
//   WORK_BYTES   : bytes per Icarus work frame
//   NONCE_BYTES  : bytes returned per golden nonce
//   MID_*/D2_MSB : bit positions of the job fields inside the 512-bit frame buffer
//   nonce_byte() : selects byte idx of a nonce, MSB first
package icarus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        MINING,
        DRAIN,
        SEND
    } state_t;

    localparam int WORK_BYTES  = 64;
    localparam int NONCE_BYTES = 4;
    localparam int BUF_BITS    = WORK_BYTES * 8;
    localparam int MID_MSB     = 511;
    localparam int MID_LSB     = 256;
    localparam int D2_MSB      = 95;

    // Byte 0 is the most significant byte so the nonce goes out big-endian.
    function automatic logic [7:0] nonce_byte(input logic [31:0] nonce, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = nonce[31:24];
            2'd1:    b = nonce[23:16];
            2'd2:    b = nonce[15:8];
            default: b = nonce[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/icarus_work_rx.sv
// Work frame assembler: shifts received bytes into a 512-bit buffer, counts
// them, drops partial frames after an idle timeout and flags complete frames.
//   clk, rst          : clock, synchronous active-high reset
//   i_rx_data/valid   : received byte and its one-cycle strobe
//   i_clear_pending   : controller has consumed the pending frame
//   o_buf             : frame buffer, first byte in [511:504]
//   o_frame_pending   : a complete frame is waiting to be loaded
module icarus_work_rx
    import icarus_pkg::*;
#(
    parameter logic [31:0] RX_TIMEOUT = 32'd1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    input  logic                i_clear_pending,
    output logic [BUF_BITS-1:0] o_buf,
    output logic                o_frame_pending
);

    logic [BUF_BITS-1:0] r_buf;
    logic [5:0]          r_cnt;
    logic [31:0]         r_idle;
    logic                r_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf     <= '0;
            r_cnt     <= '0;
            r_idle    <= '0;
            r_pending <= 1'b0;
        end else begin
            if (i_rx_valid) begin
                r_buf  <= {r_buf[BUF_BITS-9:0], i_rx_data};
                r_cnt  <= r_cnt + 6'd1;   // wraps 63 -> 0 on the last byte
                r_idle <= '0;
            end else if (r_cnt != 6'd0) begin
                // Idle gap inside a frame: drop the partial frame once the gap
                // reaches RX_TIMEOUT cycles. The stale buffer content is
                // harmless because a full frame shifts it all out.
                if (r_idle >= RX_TIMEOUT - 32'd1) begin
                    r_cnt  <= '0;
                    r_idle <= '0;
                end else if (r_idle != '1) begin
                    r_idle <= r_idle + 32'd1;
                end
            end

            // A freshly completed frame wins over a clear in the same cycle.
            if (i_rx_valid && (r_cnt == 6'(WORK_BYTES - 1))) begin
                r_pending <= 1'b1;
            end else if (i_clear_pending) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_buf           = r_buf;
    assign o_frame_pending = r_pending;

endmodule

// File: rtl/icarus_work_ctrl.sv
// Host-side job controller for the mining core. Loads jobs from received
// work frames, pulses start_mining, supervises miner_busy/got_ticket and
// returns the golden nonce as four bytes over the UART TX handshake.
//   clk, rst                  : clock, synchronous active-high reset
//   rx_data, rx_valid         : UART receive byte stream
//   tx_data, tx_valid, tx_ready : UART transmit handshake
//   midstate, data2           : job fields to the core
//   start_mining              : job start level to the core
//   miner_busy, got_ticket, golden_nonce : core status
//   ctrl_busy                 : controller is not idle
module icarus_work_ctrl
    import icarus_pkg::*;
#(
    parameter int unsigned START_CYCLES = 4,
    parameter int unsigned BUSY_WAIT    = 16,
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter logic [31:0] RX_TIMEOUT   = 32'd1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [255:0] midstate,
    output logic [95:0]  data2,
    output logic         start_mining,
    input  logic         miner_busy,
    input  logic         got_ticket,
    input  logic [31:0]  golden_nonce,
    output logic         ctrl_busy
);

    logic [BUF_BITS-1:0] w_buf;
    logic                w_frame_pending;
    logic                w_load;

    icarus_work_rx #(
        .RX_TIMEOUT (RX_TIMEOUT)
    ) u_rx (
        .clk             (clk),
        .rst             (rst),
        .i_rx_data       (rx_data),
        .i_rx_valid      (rx_valid),
        .i_clear_pending (w_load),
        .o_buf           (w_buf),
        .o_frame_pending (w_frame_pending)
    );

    state_t       r_state,    w_state_next;
    logic [15:0]  r_timer,    w_timer_next;
    logic         r_start,    w_start_next;
    logic [31:0]  r_nonce,    w_nonce_next;
    logic         r_tx_valid, w_tx_valid_next;
    logic [7:0]   r_tx_data,  w_tx_data_next;
    logic [1:0]   r_byte_idx, w_byte_idx_next;
    logic         r_ctrl_busy;
    logic [255:0] r_midstate;
    logic [95:0]  r_data2;

    always_comb begin
        w_state_next    = r_state;
        w_timer_next    = r_timer + 16'd1;
        w_start_next    = 1'b0;
        w_nonce_next    = r_nonce;
        w_tx_valid_next = r_tx_valid;
        w_tx_data_next  = r_tx_data;
        w_byte_idx_next = r_byte_idx;
        w_load          = 1'b0;

        case (r_state)
            IDLE: begin
                w_timer_next = '0;
                if (w_frame_pending) begin
                    w_load       = 1'b1;
                    w_start_next = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (r_timer == 16'(START_CYCLES - 1)) begin
                    w_timer_next = '0;
                    w_state_next = WAIT_BUSY;
                end else begin
                    w_start_next = 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (miner_busy) begin
                    w_state_next = MINING;
                end else if (r_timer == 16'(BUSY_WAIT - 1)) begin
                    w_state_next = IDLE;
                end
            end
            MINING: begin
                // A newer job preempts the running one without any report.
                if (w_frame_pending) begin
                    w_state_next = IDLE;
                end else if (got_ticket) begin
                    w_nonce_next    = golden_nonce;
                    w_byte_idx_next = '0;
                    w_state_next    = SEND;
                end else if (!miner_busy) begin
                    // The core drops busy before raising got_ticket, so wait.
                    w_timer_next = '0;
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (got_ticket) begin
                    w_nonce_next    = golden_nonce;
                    w_byte_idx_next = '0;
                    w_state_next    = SEND;
                end else if (r_timer == 16'(DRAIN_CYCLES - 1)) begin
                    w_state_next = IDLE;
                end
            end
            SEND: begin
                if (!r_tx_valid) begin
                    w_tx_valid_next = 1'b1;
                    w_tx_data_next  = nonce_byte(r_nonce, r_byte_idx);
                end else if (tx_ready) begin
                    if (r_byte_idx == 2'(NONCE_BYTES - 1)) begin
                        w_tx_valid_next = 1'b0;
                        w_byte_idx_next = '0;
                        w_state_next    = IDLE;
                    end else begin
                        // Present the next byte immediately for back-to-back transfers.
                        w_byte_idx_next = r_byte_idx + 2'd1;
                        w_tx_data_next  = nonce_byte(r_nonce, r_byte_idx + 2'd1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_start     <= 1'b0;
            r_nonce     <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_byte_idx  <= '0;
            r_ctrl_busy <= 1'b0;
            r_midstate  <= '0;
            r_data2     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_start     <= w_start_next;
            r_nonce     <= w_nonce_next;
            r_tx_valid  <= w_tx_valid_next;
            r_tx_data   <= w_tx_data_next;
            r_byte_idx  <= w_byte_idx_next;
            r_ctrl_busy <= (w_state_next != IDLE);
            if (w_load) begin
                r_midstate <= w_buf[MID_MSB:MID_LSB];
                r_data2    <= w_buf[D2_MSB:0];
            end
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign start_mining = r_start;
    assign midstate     = r_midstate;
    assign data2        = r_data2;
    assign ctrl_busy    = r_ctrl_busy;

endmodule

// File: tb/tb_icarus_work_ctrl.sv
// Testbench for icarus_work_ctrl: directed job scenarios with random frame
// contents and nonces, checked against a byte-level model of the frame and
// nonce formats.
module tb_icarus_work_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [255:0] midstate;
    logic [95:0]  data2;
    logic         start_mining;
    logic         miner_busy;
    logic         got_ticket;
    logic [31:0]  golden_nonce;
    logic         ctrl_busy;

    int n_checks = 0;
    int n_errors = 0;

    icarus_work_ctrl #(
        .START_CYCLES (4),
        .BUSY_WAIT    (16),
        .DRAIN_CYCLES (8),
        .RX_TIMEOUT   (32'd100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .midstate     (midstate),
        .data2        (data2),
        .start_mining (start_mining),
        .miner_busy   (miner_busy),
        .got_ticket   (got_ticket),
        .golden_nonce (golden_nonce),
        .ctrl_busy    (ctrl_busy)
    );

    always #5 clk = ~clk;

    // Observation on the falling edge: accepted TX bytes, start pulse widths,
    // and tx_data stability while the transmitter stalls.
    logic [7:0] tx_q[$];
    int         start_run  = 0;
    int         last_pulse = 0;
    int         pulses     = 0;
    int         stab_viol  = 0;
    logic       prev_wait  = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_q.push_back(tx_data);
        if (start_mining === 1'b1) begin
            start_run <= start_run + 1;
        end else if (start_run != 0) begin
            last_pulse <= start_run;
            pulses     <= pulses + 1;
            start_run  <= 0;
        end
        if (tx_valid === 1'b1 && prev_wait && tx_data !== prev_data) stab_viol <= stab_viol + 1;
        prev_wait <= (tx_valid === 1'b1) && (tx_ready === 1'b0);
        prev_data <= tx_data;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f [64]);
        for (int i = 0; i < 64; i++) send_byte(f[i]);
    endtask

    // Model: midstate is frame bytes 0..31, data2 is bytes 52..63, first byte most significant.
    function automatic logic [255:0] exp_mid(input logic [7:0] f [64]);
        logic [255:0] m = '0;
        for (int i = 0; i < 32; i++) m = {m[247:0], f[i]};
        return m;
    endfunction

    function automatic logic [95:0] exp_d2(input logic [7:0] f [64]);
        logic [95:0] d = '0;
        for (int i = 52; i < 64; i++) d = {d[87:0], f[i]};
        return d;
    endfunction

    task automatic wait_start(input string tag);
        int n = 0;
        while (start_mining !== 1'b1 && n < 300) begin tick(); n++; end
        check(tag, 512'(start_mining), 512'(1));
    endtask

    task automatic wait_start_fall();
        int n = 0;
        while (start_mining === 1'b1 && n < 50) begin tick(); n++; end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (ctrl_busy !== 1'b0 && n < 300) begin tick(); n++; end
        check(tag, 512'(ctrl_busy), 512'(0));
    endtask

    // Expects exactly four new bytes after base, MSB of the nonce first.
    task automatic check_tx(input string tag, input int base, input logic [31:0] nonce);
        logic [7:0] exp_b;
        check({tag, "_count"}, 512'(tx_q.size()), 512'(base + 4));
        for (int k = 0; k < 4; k++) begin
            exp_b = nonce[31 - 8*k -: 8];
            if (base + k < tx_q.size()) check($sformatf("%s_byte%0d", tag, k), 512'(tx_q[base + k]), 512'(exp_b));
        end
    endtask

    logic [7:0]  frame [64];
    logic [31:0] nonce;
    int          base;
    int          pbase;

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1;
        miner_busy = 1'b0; got_ticket = 1'b0; golden_nonce = '0;
        repeat (3) tick();
        check("rst_tx_valid", 512'(tx_valid), 512'(0));
        check("rst_tx_data", 512'(tx_data), 512'(0));
        check("rst_start", 512'(start_mining), 512'(0));
        check("rst_midstate", 512'(midstate), 512'(0));
        check("rst_data2", 512'(data2), 512'(0));
        check("rst_ctrl_busy", 512'(ctrl_busy), 512'(0));
        rst = 1'b0;
        tick();

        // 1: single job with a ticket while busy, counting-pattern frame.
        for (int i = 0; i < 64; i++) frame[i] = 8'(i);
        base = tx_q.size(); pbase = pulses;
        send_frame(frame);
        tick();   // frame_pending cycle -> start and job fields on the next
        check("t1_start_latency", 512'(start_mining), 512'(1));
        check("t1_midstate", 512'(midstate), 512'(exp_mid(frame)));
        check("t1_data2", 512'(data2), 512'(exp_d2(frame)));
        wait_start_fall();
        repeat (2) tick();
        miner_busy = 1'b1;
        repeat (10) tick();
        golden_nonce = 32'h12345678;
        got_ticket   = 1'b1;
        wait_idle("t1_idle");
        check_tx("t1_tx", base, 32'h12345678);
        check("t1_pulses", 512'(pulses), 512'(pbase + 1));
        check("t1_pulse_len", 512'(last_pulse), 512'(4));
        miner_busy = 1'b0;   // ticket stays high (stale) until the next start

        // 2: busy falls two cycles before the ticket.
        for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);
        base = tx_q.size();
        send_frame(frame);
        wait_start("t2_start");
        got_ticket = 1'b0;
        check("t2_midstate", 512'(midstate), 512'(exp_mid(frame)));
        check("t2_data2", 512'(data2), 512'(exp_d2(frame)));
        wait_start_fall();
        miner_busy = 1'b1;
        repeat (5 + $urandom_range(0, 5)) tick();
        miner_busy = 1'b0;
        repeat (2) tick();
        nonce = $urandom;
        golden_nonce = nonce;
        got_ticket   = 1'b1;
        wait_idle("t2_idle");
        check_tx("t2_tx", base, nonce);
        $display("t2 job nonce %08h sent %0d bytes", nonce, tx_q.size() - base);

        // 3: exhaustion, no ticket within the drain window.
        for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);
        base = tx_q.size();
        send_frame(frame);
        wait_start("t3_start");
        got_ticket = 1'b0;
        wait_start_fall();
        miner_busy = 1'b1;
        repeat (10) tick();
        miner_busy = 1'b0;
        repeat (5) tick();
        check("t3_drain_busy", 512'(ctrl_busy), 512'(1));
        repeat (10) tick();
        check("t3_idle", 512'(ctrl_busy), 512'(0));
        check("t3_no_tx", 512'(tx_q.size()), 512'(base));

        // 4: preemption by a 0xAA frame during MINING, stale ticket afterwards.
        for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);
        base = tx_q.size(); pbase = pulses;
        send_frame(frame);
        wait_start("t4_start_a");
        miner_busy = 1'b1;
        wait_start_fall();
        repeat (4) tick();
        for (int i = 0; i < 64; i++) frame[i] = 8'hAA;
        send_frame(frame);
        wait_start("t4_start_b");
        miner_busy = 1'b0;
        got_ticket = 1'b1;   // stale ticket must not be reported
        golden_nonce = 32'hDEADBEEF;
        check("t4_midstate", 512'(midstate), 512'(exp_mid(frame)));
        check("t4_data2", 512'(data2), 512'(exp_d2(frame)));
        wait_idle("t4_idle");
        check("t4_no_tx", 512'(tx_q.size()), 512'(base));
        check("t4_pulses", 512'(pulses), 512'(pbase + 2));
        got_ticket = 1'b0;

        // 5: partial frame dropped after the RX timeout.
        for (int i = 0; i < 10; i++) send_byte(8'($urandom));
        repeat (120) tick();
        for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);
        send_frame(frame);
        tick();
        check("t5_start", 512'(start_mining), 512'(1));
        check("t5_midstate", 512'(midstate), 512'(exp_mid(frame)));
        check("t5_data2", 512'(data2), 512'(exp_d2(frame)));
        wait_idle("t5_idle");

        // 6: TX backpressure, then reset after the second byte.
        tx_ready = 1'b0;
        for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);
        send_frame(frame);
        wait_start("t6_start");
        miner_busy = 1'b1;
        wait_start_fall();
        repeat (3) tick();
        nonce = $urandom;
        golden_nonce = nonce;
        got_ticket   = 1'b1;
        base = tx_q.size();
        for (int k = 0; k < 2; k++) begin
            repeat (5) tick();
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
        end
        rst = 1'b1;
        tick();
        check("t6_rst_tx_valid", 512'(tx_valid), 512'(0));
        check("t6_rst_ctrl_busy", 512'(ctrl_busy), 512'(0));
        check("t6_rst_midstate", 512'(midstate), 512'(0));
        rst = 1'b0; miner_busy = 1'b0; got_ticket = 1'b0; tx_ready = 1'b1;
        repeat (20) tick();
        check("t6_count", 512'(tx_q.size()), 512'(base + 2));
        if (base + 1 < tx_q.size()) begin
            check("t6_byte0", 512'(tx_q[base]), 512'(nonce[31:24]));
            check("t6_byte1", 512'(tx_q[base + 1]), 512'(nonce[23:16]));
        end
        check("t6_tx_stable", 512'(stab_viol), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
